// File: rtl/dmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_if
//   Bundles the two buses that meet at the data-memory arbiter: the MEM-stage
//   pipeline access port and the single port of the data memory itself.
//
//   Signals
//     pipe_addr   byte address from the ALU result (MEM stage)
//     pipe_wdata  store data
//     pipe_we     store in MEM this cycle
//     pipe_re     load in MEM this cycle
//     pipe_rdata  load data returned to the pipeline
//     pipe_stall  pipeline must hold MEM and earlier stages
//     mem_a       memory word address
//     mem_d       memory write data
//     mem_we      memory write enable
//     mem_spo     asynchronous read data from memory
//
//   Modports
//     master  arbiter side (drives memory port, load data and stall)
//     slave   environment side (pipeline and memory)
// -----------------------------------------------------------------------------
interface dmem_arbiter_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
);
    logic [31:0]       pipe_addr;
    logic [DATA_W-1:0] pipe_wdata;
    logic              pipe_we;
    logic              pipe_re;
    logic [DATA_W-1:0] pipe_rdata;
    logic              pipe_stall;
    logic [ADDR_W-1:0] mem_a;
    logic [DATA_W-1:0] mem_d;
    logic              mem_we;
    logic [DATA_W-1:0] mem_spo;

    modport master (
        input  pipe_addr, pipe_wdata, pipe_we, pipe_re, mem_spo,
        output pipe_rdata, pipe_stall, mem_a, mem_d, mem_we
    );

    modport slave (
        output pipe_addr, pipe_wdata, pipe_we, pipe_re, mem_spo,
        input  pipe_rdata, pipe_stall, mem_a, mem_d, mem_we
    );
endinterface

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Owns the single port of the data memory in the MEM stage and shares it
//   between the pipeline (default owner) and the board debug viewer. While the
//   debug switch is on, the viewer reads one word per cycle, shows byte 0 on the
//   LEDs and stalls any pipeline load/store. The viewed address comes from the
//   switches (manual) or from an auto-scan pointer stepped by a divider tick or
//   by a rising edge of the step button.
//
//   Ports
//     clk           system clock
//     rst_n         synchronous, active-low reset
//     bus           dmem_arbiter_if.master: pipeline port + memory port
//     dbg_en        debug-view switch (level)
//     dbg_auto      1 = auto-scan, 0 = manual address
//     dbg_addr      manual debug word address
//     dbg_step      debounced step button (level)
//     dbg_cur_addr  word address the viewer is currently showing
//     led           registered byte 0 of the viewed word, 0 outside debug
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int ADDR_W    = 7,
    parameter int DATA_W    = 32,
    parameter int SCAN_DIV  = 50_000_000,
    parameter int SCAN_LAST = 63
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dmem_arbiter_if.master        bus,
    input  logic                  dbg_en,
    input  logic                  dbg_auto,
    input  logic [5:0]            dbg_addr,
    input  logic                  dbg_step,
    output logic [5:0]            dbg_cur_addr,
    output logic [7:0]            led
);

    localparam int              DIV_W   = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCAN_DIV - 1);
    localparam logic [5:0]      PTR_LAST = 6'(SCAN_LAST);

    typedef enum logic [1:0] {
        PIPE = 2'd0,
        DBG  = 2'd1,
        EXIT = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [5:0]         ptr_q, ptr_d;
    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic [7:0]         led_q, led_d;
    logic               step_q, step_d;

    logic [ADDR_W-1:0]  mem_a_c;
    logic               mem_we_c;
    logic               stall_c;
    logic               tick_c;
    logic               step_evt_c;

    // Tag bits and byte offset of the pipeline address are deliberately dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.pipe_addr[31:ADDR_W+2], bus.pipe_addr[1:0]};

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        div_cnt_d  = '0;
        led_d      = '0;
        step_d     = dbg_step;
        mem_a_c    = bus.pipe_addr[ADDR_W+1:2];
        mem_we_c   = bus.pipe_we;
        stall_c    = 1'b0;
        tick_c     = 1'b0;
        step_evt_c = dbg_step & ~step_q;

        unique case (state_q)
            PIPE: begin
                // The access presented in this cycle still completes; the
                // viewer only takes the port from the next edge.
                if (dbg_en) begin
                    state_d = DBG;
                end
            end
            DBG: begin
                mem_a_c  = ADDR_W'(ptr_q);
                mem_we_c = 1'b0;
                stall_c  = bus.pipe_we | bus.pipe_re;
                led_d    = bus.mem_spo[7:0];
                if (dbg_auto) begin
                    tick_c    = (div_cnt_q == DIV_MAX);
                    div_cnt_d = tick_c ? '0 : div_cnt_q + 1'b1;
                    // A tick and a step in the same cycle count as one advance.
                    if (tick_c || step_evt_c) begin
                        ptr_d = (ptr_q == PTR_LAST) ? 6'd0 : ptr_q + 6'd1;
                    end
                end else begin
                    ptr_d = dbg_addr;
                end
                if (!dbg_en) begin
                    state_d = EXIT;
                end
            end
            EXIT: begin
                // Always return through PIPE so the pipeline gets at least one
                // un-stalled cycle, even if the switch flips straight back on.
                state_d = PIPE;
            end
            default: begin
                state_d = PIPE;
            end
        endcase

        // No write (and a quiet address) may reach memory while in reset.
        if (!rst_n) begin
            mem_a_c  = '0;
            mem_we_c = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= PIPE;
            ptr_q     <= '0;
            div_cnt_q <= '0;
            led_q     <= '0;
            step_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            div_cnt_q <= div_cnt_d;
            led_q     <= led_d;
            step_q    <= step_d;
        end
    end

    assign bus.mem_a      = mem_a_c;
    assign bus.mem_we     = mem_we_c;
    assign bus.mem_d      = bus.pipe_wdata;
    assign bus.pipe_rdata = bus.mem_spo;
    assign bus.pipe_stall = stall_c;
    assign dbg_cur_addr   = ptr_q;
    assign led            = led_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//   Directed bench for dmem_arbiter with a small scan configuration
//   (SCAN_DIV=4, SCAN_LAST=3) and a 128x32 behavioural data memory.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

    logic       clk;
    logic       rst_n;
    logic       dbg_en;
    logic       dbg_auto;
    logic [5:0] dbg_addr;
    logic       dbg_step;
    logic [5:0] dbg_cur_addr;
    logic [7:0] led;

    int n_chk  = 0;
    int n_fail = 0;

    dmem_arbiter_if #(.ADDR_W(7), .DATA_W(32)) bus ();

    dmem_arbiter #(
        .ADDR_W   (7),
        .DATA_W   (32),
        .SCAN_DIV (4),
        .SCAN_LAST(3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .dbg_en      (dbg_en),
        .dbg_auto    (dbg_auto),
        .dbg_addr    (dbg_addr),
        .dbg_step    (dbg_step),
        .dbg_cur_addr(dbg_cur_addr),
        .led         (led)
    );

    // Behavioural single-port memory: async read, write on the rising edge.
    logic [31:0] mem [128] = '{default: 32'h0};
    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_a] <= bus.mem_d;
    end
    assign bus.mem_spo = mem[bus.mem_a];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic        re;
        logic [6:0]  exp_a;
        logic        chk_rd;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [12];

    initial begin
        vecs[0]  = '{32'h0000_0010, 32'hA5A5_0001, 1'b1, 1'b0, 7'd4,   1'b0, 32'h0};
        vecs[1]  = '{32'h0000_0010, 32'h0,         1'b0, 1'b1, 7'd4,   1'b1, 32'hA5A5_0001};
        vecs[2]  = '{32'h0000_0204, 32'h1234_5678, 1'b1, 1'b0, 7'd1,   1'b0, 32'h0};
        vecs[3]  = '{32'h0000_0007, 32'h0,         1'b0, 1'b1, 7'd1,   1'b1, 32'h1234_5678};
        vecs[4]  = '{32'hFFFF_FFFC, 32'hDEAD_BEEF, 1'b1, 1'b0, 7'd127, 1'b0, 32'h0};
        vecs[5]  = '{32'h0000_01FC, 32'h0,         1'b0, 1'b1, 7'd127, 1'b1, 32'hDEAD_BEEF};
        vecs[6]  = '{32'h0000_0014, 32'h0000_00C3, 1'b1, 1'b0, 7'd5,   1'b0, 32'h0};
        vecs[7]  = '{32'h0000_000C, 32'h0000_005A, 1'b1, 1'b0, 7'd3,   1'b0, 32'h0};
        vecs[8]  = '{32'h0000_0008, 32'h0000_0077, 1'b1, 1'b0, 7'd2,   1'b0, 32'h0};
        vecs[9]  = '{32'h0000_0000, 32'h0000_0011, 1'b1, 1'b0, 7'd0,   1'b0, 32'h0};
        vecs[10] = '{32'h0000_0014, 32'h0,         1'b0, 1'b1, 7'd5,   1'b1, 32'h0000_00C3};
        vecs[11] = '{32'h0000_0204, 32'h0,         1'b0, 1'b1, 7'd1,   1'b1, 32'h1234_5678};

        rst_n          = 1'b0;
        dbg_en         = 1'b0;
        dbg_auto       = 1'b0;
        dbg_addr       = 6'd0;
        dbg_step       = 1'b0;
        bus.pipe_addr  = 32'h0000_0010;
        bus.pipe_wdata = 32'h5555_5555;
        bus.pipe_we    = 1'b1;
        bus.pipe_re    = 1'b0;

        // Reset state: no write leaks out even with a store presented.
        step_clk();
        step_clk();
        check("rst_mem_we",   32'(bus.mem_we), 32'd0);
        check("rst_mem_a",    32'(bus.mem_a), 32'd0);
        check("rst_led",      32'(led), 32'd0);
        check("rst_cur_addr", 32'(dbg_cur_addr), 32'd0);
        check("rst_no_write", mem[4], 32'h0);
        rst_n       = 1'b1;
        bus.pipe_we = 1'b0;
        step_clk();

        // Pipeline-only vectors.
        for (int i = 0; i < 12; i++) begin
            bus.pipe_addr  = vecs[i].addr;
            bus.pipe_wdata = vecs[i].wdata;
            bus.pipe_we    = vecs[i].we;
            bus.pipe_re    = vecs[i].re;
            #1;
            check($sformatf("vec%0d_mem_a", i),  32'(bus.mem_a), 32'(vecs[i].exp_a));
            check($sformatf("vec%0d_mem_we", i), 32'(bus.mem_we), 32'(vecs[i].we));
            check($sformatf("vec%0d_stall", i),  32'(bus.pipe_stall), 32'd0);
            if (vecs[i].we)
                check($sformatf("vec%0d_mem_d", i), bus.mem_d, vecs[i].wdata);
            if (vecs[i].chk_rd)
                check($sformatf("vec%0d_rdata", i), bus.pipe_rdata, vecs[i].exp_rd);
            step_clk();
        end
        check("led_pipe", 32'(led), 32'd0);

        // Manual view of word 5.
        bus.pipe_we = 1'b0;
        bus.pipe_re = 1'b0;
        dbg_en      = 1'b1;
        dbg_auto    = 1'b0;
        dbg_addr    = 6'd5;
        step_clk();
        check("man_idle_stall", 32'(bus.pipe_stall), 32'd0);
        check("man_mem_we",     32'(bus.mem_we), 32'd0);
        step_clk();
        check("man_cur_addr", 32'(dbg_cur_addr), 32'd5);
        check("man_mem_a",    32'(bus.mem_a), 32'd5);
        step_clk();
        check("man_led", 32'(led), 32'hC3);

        // Store while the viewer owns the port.
        bus.pipe_addr  = 32'h0000_0020;
        bus.pipe_wdata = 32'hCAFE_0008;
        bus.pipe_we    = 1'b1;
        #1;
        check("stall_on",     32'(bus.pipe_stall), 32'd1);
        check("stall_mem_we", 32'(bus.mem_we), 32'd0);
        step_clk();
        check("stall_no_write", mem[8], 32'h0);
        dbg_en = 1'b0;
        #1;
        check("stall_last_dbg", 32'(bus.pipe_stall), 32'd1);
        step_clk();
        check("exit_stall",  32'(bus.pipe_stall), 32'd0);
        check("exit_mem_we", 32'(bus.mem_we), 32'd1);
        check("exit_mem_a",  32'(bus.mem_a), 32'd8);
        step_clk();
        check("exit_led",      32'(led), 32'd0);
        check("reissue_write", mem[8], 32'hCAFE_0008);
        bus.pipe_we = 1'b0;

        // Re-entering debug during EXIT still passes through PIPE.
        bus.pipe_addr = 32'h0000_0010;
        bus.pipe_re   = 1'b1;
        dbg_en        = 1'b1;
        #1;
        check("reent_pipe_stall", 32'(bus.pipe_stall), 32'd0);
        check("reent_rdata",      bus.pipe_rdata, 32'hA5A5_0001);
        step_clk();
        check("reent_dbg_stall", 32'(bus.pipe_stall), 32'd1);
        dbg_en = 1'b0;
        step_clk();
        dbg_en = 1'b1;
        #1;
        check("reent_exit_stall", 32'(bus.pipe_stall), 32'd0);
        step_clk();
        check("reent_pipe2_stall", 32'(bus.pipe_stall), 32'd0);
        step_clk();
        check("reent_dbg2_stall", 32'(bus.pipe_stall), 32'd1);
        bus.pipe_re = 1'b0;

        // Auto-scan from ptr=2 with SCAN_DIV=4, SCAN_LAST=3.
        dbg_addr = 6'd2;
        step_clk();
        check("auto_start_ptr", 32'(dbg_cur_addr), 32'd2);
        dbg_auto = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            logic [5:0] exp_ptr;
            step_clk();
            if (k < 4)       exp_ptr = 6'd2;
            else if (k < 8)  exp_ptr = 6'd3;
            else if (k < 12) exp_ptr = 6'd0;
            else             exp_ptr = 6'd1;
            if (k == 3 || k == 4 || k == 8 || k == 12 || k == 15)
                check($sformatf("auto_ptr_k%0d", k), 32'(dbg_cur_addr), 32'(exp_ptr));
            if (k == 7)
                check("auto_led_w3", 32'(led), 32'h5A);
        end
        // Step pressed on the tick cycle: one advance only.
        dbg_step = 1'b1;
        step_clk();
        check("tick_and_step", 32'(dbg_cur_addr), 32'd2);
        step_clk();
        check("step_held", 32'(dbg_cur_addr), 32'd2);
        dbg_step = 1'b0;
        step_clk();
        check("step_release", 32'(dbg_cur_addr), 32'd2);
        dbg_step = 1'b1;
        step_clk();
        check("step_alone", 32'(dbg_cur_addr), 32'd3);
        dbg_step = 1'b0;
        step_clk();
        check("scan_wrap", 32'(dbg_cur_addr), 32'd0);
        check("led_w3_prev", 32'(led), 32'h5A);
        step_clk();
        check("led_w0", 32'(led), 32'h11);

        // Reset while in debug with a store pending.
        bus.pipe_addr  = 32'h0000_0040;
        bus.pipe_wdata = 32'hBAD0_BAD0;
        bus.pipe_we    = 1'b1;
        rst_n          = 1'b0;
        #1;
        check("dbgrst_mem_we", 32'(bus.mem_we), 32'd0);
        check("dbgrst_mem_a",  32'(bus.mem_a), 32'd0);
        step_clk();
        check("dbgrst_led",      32'(led), 32'd0);
        check("dbgrst_ptr",      32'(dbg_cur_addr), 32'd0);
        check("dbgrst_stall",    32'(bus.pipe_stall), 32'd0);
        check("dbgrst_no_write", mem[16], 32'h0);
        rst_n       = 1'b1;
        dbg_en      = 1'b0;
        bus.pipe_we = 1'b0;
        bus.pipe_re = 1'b1;
        bus.pipe_addr = 32'h0000_0010;
        #1;
        check("post_rst_rdata", bus.pipe_rdata, 32'hA5A5_0001);
        check("post_rst_stall", 32'(bus.pipe_stall), 32'd0);
        step_clk();
        check("post_rst_pipe_stall", 32'(bus.pipe_stall), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
